// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Run sequencer and performance monitor. Launches one of NPROG
//               programs from a loaded entry-address table, detects the
//               all-ones halt opcode, counts cycles / retired instructions /
//               taken jumps (saturating), enforces an optional cycle timeout
//               and reports completion through Ack plus a status code.
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl #(
    parameter int IW    = 9,
    parameter int PCW   = 10,
    parameter int CW    = 16,
    parameter int NPROG = 3,
    localparam int PSW  = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [PSW-1:0] i_prog_sel,
    input  logic           i_abort,
    input  logic           i_cfg_wr_en,
    input  logic [PSW-1:0] i_cfg_idx,
    input  logic [PCW-1:0] i_cfg_addr,
    input  logic [CW-1:0]  i_timeout_limit,
    input  logic [IW-1:0]  i_instruction,
    input  logic           i_retire,
    input  logic           i_taken_jump,
    output logic           o_core_start,
    output logic [PCW-1:0] o_entry_pc,
    output logic           o_running,
    output logic           o_ack,
    output logic [1:0]     o_status,
    output logic [CW-1:0]  o_cycle_ct,
    output logic [CW-1:0]  o_inst_ct,
    output logic [CW-1:0]  o_jump_ct
);

    localparam logic [1:0]   c_ST_NONE    = 2'b00;
    localparam logic [1:0]   c_ST_HALTED  = 2'b01;
    localparam logic [1:0]   c_ST_TIMEOUT = 2'b10;
    localparam logic [1:0]   c_ST_ABORTED = 2'b11;
    localparam logic [PSW:0] c_NPROG      = (PSW+1)'(NPROG);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PCW-1:0]  r_table [NPROG];
    logic [PCW-1:0]  r_entry_pc;
    logic [CW-1:0]   r_cycle_ct;
    logic [CW-1:0]   r_inst_ct;
    logic [CW-1:0]   r_jump_ct;
    logic [1:0]      r_status;

    logic            w_sel_ok;
    logic            w_accept;
    logic            w_status_we;
    logic [1:0]      w_status_nxt;
    logic            w_halt;
    logic            w_timeout;
    logic [CW-1:0]   w_cycle_inc;
    logic [CW-1:0]   w_inst_inc;
    logic [CW-1:0]   w_jump_inc;

    // Saturating increments: a counter at all-ones stays there.
    assign w_cycle_inc = (&r_cycle_ct) ? r_cycle_ct : r_cycle_ct + CW'(1);
    assign w_inst_inc  = (&r_inst_ct)  ? r_inst_ct  : r_inst_ct  + CW'(1);
    assign w_jump_inc  = (&r_jump_ct)  ? r_jump_ct  : r_jump_ct  + CW'(1);

    assign w_sel_ok  = ({1'b0, i_prog_sel} < c_NPROG);
    assign w_halt    = &i_instruction;
    // Compare against the post-increment count so DONE lands on exactly the limit.
    assign w_timeout = (i_timeout_limit != '0) && (w_cycle_inc == i_timeout_limit);

    // Entry-address table; writes to slots at or beyond NPROG match no slot and vanish.
    for (genvar g = 0; g < NPROG; g++) begin : g_table
        // One table slot, cleared by reset.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_table[g] <= '0;
            end else if (i_cfg_wr_en && ({1'b0, i_cfg_idx} == (PSW+1)'(g))) begin
                r_table[g] <= i_cfg_addr;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode with exit priority Abort > halt > timeout.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_status_we  = 1'b0;
        w_status_nxt = r_status;
        if (i_abort) begin
            w_next_state = S_IDLE;
            w_status_we  = 1'b1;
            w_status_nxt = c_ST_ABORTED;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start && w_sel_ok) begin
                        w_next_state = S_LAUNCH;
                        w_accept     = 1'b1;
                        w_status_we  = 1'b1;
                        w_status_nxt = c_ST_NONE;
                    end
                end
                S_LAUNCH: begin
                    w_next_state = S_RUN;
                end
                S_RUN: begin
                    if (w_halt) begin
                        w_next_state = S_DONE;
                        w_status_we  = 1'b1;
                        w_status_nxt = c_ST_HALTED;
                    end else if (w_timeout) begin
                        w_next_state = S_DONE;
                        w_status_we  = 1'b1;
                        w_status_nxt = c_ST_TIMEOUT;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Entry PC is captured when the launch is accepted, so a table write during
    // LAUNCH cannot disturb the address the core is loading.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_entry_pc <= '0;
        end else if (w_accept) begin
            r_entry_pc <= r_table[i_prog_sel];
        end
    end

    // Performance counters: cleared on launch, counting only in RUN (including the exit cycle).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle_ct <= '0;
            r_inst_ct  <= '0;
            r_jump_ct  <= '0;
        end else if (w_accept) begin
            r_cycle_ct <= '0;
            r_inst_ct  <= '0;
            r_jump_ct  <= '0;
        end else if (r_state == S_RUN) begin
            r_cycle_ct <= w_cycle_inc;
            if (i_retire) begin
                r_inst_ct <= w_inst_inc;
            end
            if (i_taken_jump) begin
                r_jump_ct <= w_jump_inc;
            end
        end
    end

    // Completion status register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_status <= c_ST_NONE;
        end else if (w_status_we) begin
            r_status <= w_status_nxt;
        end
    end

    assign o_core_start = (r_state == S_LAUNCH);
    assign o_running    = (r_state == S_RUN);
    assign o_ack        = (r_state == S_DONE);
    assign o_entry_pc   = r_entry_pc;
    assign o_status     = r_status;
    assign o_cycle_ct   = r_cycle_ct;
    assign o_inst_ct    = r_inst_ct;
    assign o_jump_ct    = r_jump_ct;

endmodule
`default_nettype wire
